vga_pixel_engine: RTL

Parametrised successor to the fixed 640x480 monochrome VGA controller. It runs entirely in the pixel-clock domain and generates VGA timing from parameterised porch and sync widths. It fetches frame-buffer words through a generic read port with configurable latency and unpacks 1/2/4-bit pixels with integer pixel/line replication. It double-buffers the frame base address at frame wrap and drives registered RGB444 plus syncs to the VGA pins.

---
 rtl/vga_pixel_engine.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/vga_pixel_engine.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pixel_engine
//  Description : Parameterised VGA timing generator and frame-buffer pixel
//                engine. Fetches packed 1/2/4-bit pixels through a fixed-
//                latency read port, replicates pixels and lines by
//                2^SCALE_LOG2 and drives registered RGB444 plus syncs.
//                Optional macro VGA_PALETTE_EN adds a 16x12-bit palette.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_pixel_engine #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int SYNC_POL   = 0,
    parameter int BPP        = 1,
    parameter int SCALE_LOG2 = 0,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 13,
    parameter int RD_LAT     = 1
) (
    input  logic              QClk,
    input  logic              Reset_N,
`ifdef VGA_PALETTE_EN
    input  logic              PalWrEn,
    input  logic [3:0]        PalAddr,
    input  logic [11:0]       PalData,
`endif
    input  logic [ADDR_W-1:0] FrameBase,
    output logic              RdEn,
    output logic [ADDR_W-1:0] RdAddr,
    input  logic [DATA_W-1:0] RdData,
    output logic [3:0]        RED,
    output logic [3:0]        GREEN,
    output logic [3:0]        BLUE,
    output logic              h_sync,
    output logic              v_sync,
    output logic              FrameStart
);

    localparam int c_H_TOT   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOT   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_H_W     = $clog2(c_H_TOT);
    localparam int c_V_W     = $clog2(c_V_TOT);
    localparam int c_PPW     = DATA_W / BPP;
    localparam int c_WPL     = (H_ACTIVE * BPP) / (DATA_W << SCALE_LOG2);
    localparam int c_OFF_W   = $clog2(c_PPW);
    localparam int c_BPP_L2  = $clog2(BPP);
    localparam int c_BIT_W   = $clog2(DATA_W);

    localparam logic [c_H_W-1:0]  c_H_LAST    = c_H_W'(c_H_TOT - 1);
    localparam logic [c_V_W-1:0]  c_V_LAST    = c_V_W'(c_V_TOT - 1);
    localparam logic [c_H_W-1:0]  c_H_ACT     = c_H_W'(H_ACTIVE);
    localparam logic [c_V_W-1:0]  c_V_ACT     = c_V_W'(V_ACTIVE);
    // One extra bit so a sync that ends exactly at the line total still fits
    localparam logic [c_H_W:0]    c_HS_START  = (c_H_W+1)'(H_ACTIVE + H_FP);
    localparam logic [c_H_W:0]    c_HS_END    = (c_H_W+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [c_V_W:0]    c_VS_START  = (c_V_W+1)'(V_ACTIVE + V_FP);
    localparam logic [c_V_W:0]    c_VS_END    = (c_V_W+1)'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [c_H_W-1:0]  c_REP_MASK  = c_H_W'((1 << SCALE_LOG2) - 1);
    localparam logic [ADDR_W-1:0] c_WPL_A     = ADDR_W'(c_WPL);
    localparam logic              c_SYNC_ON   = (SYNC_POL != 0) ? 1'b1 : 1'b0;
    localparam logic              c_SYNC_OFF  = ~c_SYNC_ON;

    // Reject configurations the unpacking datapath cannot represent
    generate
        if (BPP != 1 && BPP != 2 && BPP != 4) begin : g_err_bpp
            $error("vga_pixel_engine: BPP must be 1, 2 or 4");
        end
        if ((H_ACTIVE * BPP) % (DATA_W << SCALE_LOG2) != 0) begin : g_err_hact
            $error("vga_pixel_engine: H_ACTIVE*BPP must be a multiple of DATA_W<<SCALE_LOG2");
        end
        if (V_ACTIVE % (1 << SCALE_LOG2) != 0) begin : g_err_vact
            $error("vga_pixel_engine: V_ACTIVE must be a multiple of 2^SCALE_LOG2");
        end
        if (c_PPW < 2 || (1 << c_OFF_W) != c_PPW) begin : g_err_ppw
            $error("vga_pixel_engine: DATA_W/BPP must be a power of two >= 2");
        end
        if (RD_LAT < 1 || RD_LAT > 4 || SCALE_LOG2 < 0 || SCALE_LOG2 > 3) begin : g_err_range
            $error("vga_pixel_engine: RD_LAT must be 1..4 and SCALE_LOG2 0..3");
        end
    endgenerate

    logic [c_H_W-1:0]   r_hcount;
    logic [c_V_W-1:0]   r_vcount;
    logic [ADDR_W-1:0]  r_fbq;

    logic [c_H_W-1:0]   w_sx;
    logic [c_V_W-1:0]   w_sy;
    logic [c_OFF_W-1:0] w_off;
    logic               w_act;
    logic               w_fetch;
    logic               w_hs;
    logic               w_vs;
    logic               w_fs;
    logic [ADDR_W-1:0]  w_rd_addr;

    // Per-cycle attributes travel RD_LAT+1 stages to meet the returning data
    logic [RD_LAT:0]    r_p_act;
    logic [RD_LAT:0]    r_p_load;
    logic [RD_LAT:0]    r_p_hs;
    logic [RD_LAT:0]    r_p_vs;
    logic [RD_LAT:0]    r_p_fs;
    logic [c_OFF_W-1:0] r_p_off [0:RD_LAT];

    logic [DATA_W-1:0]  r_word;
    logic [DATA_W-1:0]  w_word;
    logic [c_BIT_W-1:0] w_bitpos;
    logic [BPP-1:0]     w_idx;
    logic [11:0]        w_rgb;

    assign w_sx      = r_hcount >> SCALE_LOG2;
    assign w_sy      = r_vcount >> SCALE_LOG2;
    assign w_off     = w_sx[c_OFF_W-1:0];
    assign w_act     = (r_hcount < c_H_ACT) && (r_vcount < c_V_ACT);
    assign w_fetch   = w_act && (w_off == '0) && ((r_hcount & c_REP_MASK) == '0);
    assign w_hs      = ({1'b0, r_hcount} >= c_HS_START && {1'b0, r_hcount} < c_HS_END)
                       ? c_SYNC_ON : c_SYNC_OFF;
    assign w_vs      = ({1'b0, r_vcount} >= c_VS_START && {1'b0, r_vcount} < c_VS_END)
                       ? c_SYNC_ON : c_SYNC_OFF;
    assign w_fs      = (r_hcount == '0) && (r_vcount == '0);
    // Address arithmetic is done in ADDR_W bits so it wraps naturally
    assign w_rd_addr = r_fbq + ADDR_W'(w_sy) * c_WPL_A + ADDR_W'(w_sx >> c_OFF_W);

    // Raster counters; the frame base is re-latched on the last pixel of a frame
    always_ff @(posedge QClk or negedge Reset_N) begin
        if (!Reset_N) begin
            r_hcount <= '0;
            r_vcount <= '0;
            r_fbq    <= '0;
        end else if (r_hcount == c_H_LAST) begin
            r_hcount <= '0;
            if (r_vcount == c_V_LAST) begin
                r_vcount <= '0;
                r_fbq    <= FrameBase;
            end else begin
                r_vcount <= r_vcount + 1'b1;
            end
        end else begin
            r_hcount <= r_hcount + 1'b1;
        end
    end

    // Read request register plus the attribute delay line
    always_ff @(posedge QClk or negedge Reset_N) begin
        if (!Reset_N) begin
            RdEn     <= 1'b0;
            RdAddr   <= '0;
            r_p_act  <= '0;
            r_p_load <= '0;
            r_p_fs   <= '0;
            r_p_hs   <= {(RD_LAT+1){c_SYNC_OFF}};
            r_p_vs   <= {(RD_LAT+1){c_SYNC_OFF}};
            for (int k = 0; k <= RD_LAT; k++) begin
                r_p_off[k] <= '0;
            end
        end else begin
            RdEn <= w_fetch;
            if (w_fetch) begin
                RdAddr <= w_rd_addr;
            end
            r_p_act    <= {r_p_act[RD_LAT-1:0],  w_act};
            r_p_load   <= {r_p_load[RD_LAT-1:0], w_fetch};
            r_p_fs     <= {r_p_fs[RD_LAT-1:0],   w_fs};
            r_p_hs     <= {r_p_hs[RD_LAT-1:0],   w_hs};
            r_p_vs     <= {r_p_vs[RD_LAT-1:0],   w_vs};
            r_p_off[0] <= w_off;
            for (int k = 1; k <= RD_LAT; k++) begin
                r_p_off[k] <= r_p_off[k-1];
            end
        end
    end

    // The first pixel of a word uses RdData directly; later ones use the held copy
    assign w_word   = r_p_load[RD_LAT] ? RdData : r_word;
    assign w_bitpos = c_BIT_W'(r_p_off[RD_LAT]) << c_BPP_L2;
    assign w_idx    = w_word[w_bitpos +: BPP];

`ifdef VGA_PALETTE_EN
    logic [11:0] r_pal [0:15];

    // Palette storage; intentionally not reset
    always_ff @(posedge QClk) begin
        if (PalWrEn) begin
            r_pal[PalAddr] <= PalData;
        end
    end

    assign w_rgb = r_pal[4'(w_idx)];
`else
    assign w_rgb = {3{{(4 / BPP){w_idx}}}};
`endif

    // Word hold register and the final pin registers
    always_ff @(posedge QClk or negedge Reset_N) begin
        if (!Reset_N) begin
            r_word     <= '0;
            RED        <= 4'h0;
            GREEN      <= 4'h0;
            BLUE       <= 4'h0;
            h_sync     <= c_SYNC_OFF;
            v_sync     <= c_SYNC_OFF;
            FrameStart <= 1'b0;
        end else begin
            if (r_p_load[RD_LAT]) begin
                r_word <= RdData;
            end
            RED        <= r_p_act[RD_LAT] ? w_rgb[11:8] : 4'h0;
            GREEN      <= r_p_act[RD_LAT] ? w_rgb[7:4]  : 4'h0;
            BLUE       <= r_p_act[RD_LAT] ? w_rgb[3:0]  : 4'h0;
            h_sync     <= r_p_hs[RD_LAT];
            v_sync     <= r_p_vs[RD_LAT];
            FrameStart <= r_p_fs[RD_LAT];
        end
    end

endmodule
`default_nettype wire
